// File: rtl/muxn_pipe.sv
// rtl/muxn_pipe.sv - N-to-1 word select feeding a two-entry valid/ready skid buffer
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   din        N input words, word i at din[i*WIDTH +: WIDTH]
//   sel        index of the word to forward
//   in_valid   din/sel beat offered
//   in_ready   registered: block can take a beat this cycle
//   flush      drop every buffered beat (wins over accept and release)
//   dout       selected word of the head beat
//   dout_err   head beat was offered with sel >= N
//   out_valid  dout/dout_err hold a beat
//   out_ready  consumer takes the head beat
module muxn_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_err,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] main_data, main_data_n;
  logic [WIDTH-1:0] skid_data, skid_data_n;
  logic             main_err, main_err_n;
  logic             skid_err, skid_err_n;
  logic             main_vld, main_vld_n;
  logic             skid_vld, skid_vld_n;
  logic             rdy_q;

  logic [WIDTH-1:0] pick_data;
  logic             pick_err;
  logic             do_accept;
  logic             do_release;

  // Word select; an index with no matching input yields zero data and err.
  always_comb begin
    pick_data = '0;
    pick_err  = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) begin
        pick_data = din[i*WIDTH +: WIDTH];
        pick_err  = 1'b0;
      end
    end
  end

  assign do_accept  = in_valid && rdy_q;
  assign do_release = main_vld && out_ready;

  // Occupancy is encoded by the two valid bits: main only ever empties when
  // skid is already empty, so {skid_vld, main_vld} = 2'b10 never occurs.
  always_comb begin
    main_data_n = main_data;
    main_err_n  = main_err;
    main_vld_n  = main_vld;
    skid_data_n = skid_data;
    skid_err_n  = skid_err;
    skid_vld_n  = skid_vld;
    if (flush) begin
      main_vld_n = 1'b0;
      skid_vld_n = 1'b0;
    end else if (skid_vld) begin
      // Full: rdy_q is low here, so only a release can happen.
      if (do_release) begin
        main_data_n = skid_data;
        main_err_n  = skid_err;
        skid_vld_n  = 1'b0;
      end
    end else if (main_vld) begin
      if (do_accept && do_release) begin
        main_data_n = pick_data;
        main_err_n  = pick_err;
      end else if (do_accept) begin
        skid_data_n = pick_data;
        skid_err_n  = pick_err;
        skid_vld_n  = 1'b1;
      end else if (do_release) begin
        main_vld_n = 1'b0;
      end
    end else if (do_accept) begin
      main_data_n = pick_data;
      main_err_n  = pick_err;
      main_vld_n  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_data <= '0;
      main_err  <= 1'b0;
      main_vld  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
      skid_vld  <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      main_data <= main_data_n;
      main_err  <= main_err_n;
      main_vld  <= main_vld_n;
      skid_data <= skid_data_n;
      skid_err  <= skid_err_n;
      skid_vld  <= skid_vld_n;
      // Ready for next cycle whenever the buffer will not be full.
      rdy_q     <= !(main_vld_n && skid_vld_n);
    end
  end

  assign in_ready  = rdy_q;
  assign dout      = main_data;
  assign dout_err  = main_err;
  assign out_valid = main_vld;

endmodule

// File: tb/tb_muxn_pipe.sv
// tb/tb_muxn_pipe.sv - self-checking bench for muxn_pipe
module tb_muxn_pipe;

  typedef struct {
    logic [127:0] din;
    logic [1:0]   sel;
    logic [31:0]  exp_dout;
    logic         exp_err;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [127:0] din;
  logic [1:0]   sel;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [31:0]  dout;
  logic         dout_err;
  logic         out_valid;
  logic         out_ready;

  logic [95:0]  din3;
  logic [1:0]   sel3;
  logic         in_valid3;
  logic         in_ready3;
  logic         flush3;
  logic [31:0]  dout3;
  logic         dout_err3;
  logic         out_valid3;
  logic         out_ready3;

  int           checks;
  int           fails;
  logic [32:0]  sb[$];
  logic [32:0]  cur_exp;
  vec_t         tbl[12];
  bit           streaming;
  int           cyc;
  int           ir_low;
  int           n_rel;
  int           first_rel;
  int           last_rel;

  muxn_pipe #(.WIDTH(32), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .dout(dout), .dout_err(dout_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  muxn_pipe #(.WIDTH(32), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel3), .in_valid(in_valid3),
    .in_ready(in_ready3), .flush(flush3), .dout(dout3), .dout_err(dout_err3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [1:0] s, input logic [31:0] e);
    vec_t v;
    v.din      = {w3, w2, w1, w0};
    v.sel      = s;
    v.exp_dout = e;
    v.exp_err  = 1'b0;
    return v;
  endfunction

  // Monitor: sampled mid-cycle, so each condition seen here is what the
  // next rising edge will act on.
  always @(negedge clk) begin
    logic [32:0] e;
    cyc++;
    if (in_valid) begin
      checks++;
      if ($isunknown(sel)) begin
        fails++;
        $display("FAIL sel_known: sel is %b while in_valid", sel);
      end
    end
    if (streaming && !in_ready) ir_low++;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (streaming) begin
          if (n_rel == 0) first_rel = cyc;
          last_rel = cyc;
          n_rel++;
        end
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL sb_unexpected: got beat %h, expected none", dout);
        end else begin
          e = sb.pop_front();
          check("sb_dout", dout, e[31:0]);
          check("sb_err", {31'b0, dout_err}, {31'b0, e[32]});
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  // Called and returns 1 time unit after a rising edge.
  task automatic send(input vec_t v);
    int n;
    din      = v.din;
    sel      = v.sel;
    cur_exp  = {v.exp_err, v.exp_dout};
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Flush while holding `preload` beats (1 or 2) with a new beat offered.
  task automatic flush_case(input int preload);
    out_ready = 1'b0;
    send(tbl[9]);
    if (preload == 2) send(tbl[10]);
    din      = tbl[11].din;
    sel      = tbl[11].sel;
    cur_exp  = {1'b0, tbl[11].exp_dout};
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("flush_no_output", out_valid, 0);
    check("flush_sb_empty", sb.size(), 0);
  endtask

  initial begin
    clk = 0; rst_n = 0; din = '0; sel = '0; in_valid = 0; flush = 0; out_ready = 0;
    din3 = '0; sel3 = '0; in_valid3 = 0; flush3 = 0; out_ready3 = 0;
    checks = 0; fails = 0; cur_exp = '0; streaming = 0; cyc = 0;
    ir_low = 0; n_rel = 0; first_rel = 0; last_rel = 0;

    tbl[0]  = mk(32'h11, 32'h22, 32'h33, 32'h44, 2'd2, 32'h33);
    tbl[1]  = mk(32'h00, 32'h01, 32'h02, 32'h03, 2'd0, 32'h00);
    tbl[2]  = mk(32'h10, 32'h11, 32'h12, 32'h13, 2'd1, 32'h11);
    tbl[3]  = mk(32'h20, 32'h21, 32'h22, 32'h23, 2'd2, 32'h22);
    tbl[4]  = mk(32'h30, 32'h31, 32'h32, 32'h33, 2'd3, 32'h33);
    tbl[5]  = mk(32'h40, 32'h41, 32'h42, 32'h43, 2'd0, 32'h40);
    tbl[6]  = mk(32'h50, 32'h51, 32'h52, 32'h53, 2'd1, 32'h51);
    tbl[7]  = mk(32'h60, 32'h61, 32'h62, 32'h63, 2'd2, 32'h62);
    tbl[8]  = mk(32'h70, 32'h71, 32'h72, 32'h73, 2'd3, 32'h73);
    tbl[9]  = mk(32'hA0, 32'hA1, 32'hA2, 32'hA3, 2'd1, 32'hA1);
    tbl[10] = mk(32'hB0, 32'hB1, 32'hB2, 32'hB3, 2'd3, 32'hB3);
    tbl[11] = mk(32'hC0, 32'hC1, 32'hC2, 32'hC3, 2'd0, 32'hC0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_err", dout_err, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_in_ready3", in_ready3, 1);

    // Out-of-range select on the 3-input instance
    din3 = {32'hC3, 32'hB2, 32'hA1};
    sel3 = 2'd3;
    in_valid3 = 1'b1;
    out_ready3 = 1'b1;
    @(posedge clk);
    #1;
    check("oor_valid", out_valid3, 1);
    check("oor_dout", dout3, 0);
    check("oor_err", dout_err3, 1);
    sel3 = 2'd1;
    @(posedge clk);
    #1;
    in_valid3 = 1'b0;
    check("inr_valid", out_valid3, 1);
    check("inr_dout", dout3, 32'hB2);
    check("inr_err", dout_err3, 0);
    @(posedge clk);
    #1;
    check("oor_idle", out_valid3, 0);

    // Single beat, one-cycle latency
    out_ready = 1'b1;
    send(tbl[0]);
    check("single_latency", out_valid, 1);
    check("single_dout", dout, 32'h33);
    @(posedge clk);
    #1;
    check("single_done", out_valid, 0);

    // Streaming
    streaming = 1'b1;
    for (int k = 1; k <= 8; k++) send(tbl[k]);
    drain();
    streaming = 1'b0;
    check("stream_beats", n_rel, 8);
    check("stream_no_gap", last_rel - first_rel + 1, 8);
    check("stream_in_ready_low", ir_low, 0);

    // Back-pressure
    out_ready = 1'b0;
    send(tbl[9]);
    send(tbl[10]);
    check("bp_in_ready", in_ready, 0);
    din      = tbl[11].din;
    sel      = tbl[11].sel;
    cur_exp  = {1'b0, tbl[11].exp_dout};
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_dout", dout, 32'hA1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(tbl[11]);
    drain();

    // Flush
    flush_case(2);
    flush_case(1);

    // Reset mid-stream with two beats buffered
    out_ready = 1'b0;
    send(tbl[9]);
    send(tbl[10]);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_dout", dout, 0);
    check("mid_rst_err", dout_err, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    check("mid_rst_in_ready_back", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_output", out_valid, 0);

    // Normal traffic after reset
    send(tbl[4]);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
